// File: rtl/qdiv_seq.sv
// Sequential restoring divider for signed-magnitude Q-format operands.
// Produces one quotient bit per clock, with a start/done handshake and saturating result formation.
module qdiv_seq #(
   parameter int Q = 16,
   parameter int N = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_quotient,
   output logic         o_ovr,
   output logic         o_div_zero
);

   localparam int M  = N - 1;
   localparam int W  = N - 1 + Q;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  wrk;
   logic [M-1:0]  rem;
   logic [M-1:0]  dvs;
   logic          sgn;
   logic          dz;

   logic          load;
   logic [M:0]    trial;
   logic [M:0]    diff;
   logic          ge;
   logic [M-1:0]  rem_nxt;

   // wrk starts as the shifted dividend; quotient bits fill it from the LSB as dividend bits leave the MSB
   assign load    = i_start && (state == IDLE || state == DONE);
   assign trial   = {rem, wrk[W-1]};
   assign diff    = trial - {1'b0, dvs};
   assign ge      = (trial >= {1'b0, dvs});
   assign rem_nxt = ge ? diff[M-1:0] : trial[M-1:0];

   // Returns {ovr, div_zero, quotient}
   function automatic logic [N+1:0] form_result(input logic [W-1:0] q,
                                                input logic         s,
                                                input logic         z);
      logic [M-1:0] mag;
      logic         ovr;
      logic         sign;
      ovr = 1'b0;
      if (z) begin
         mag = '1;
      end else if (|q[W-1:M]) begin
         mag = '1;
         ovr = 1'b1;
      end else begin
         mag = q[M-1:0];
      end
      sign = (mag == '0) ? 1'b0 : s;
      return {ovr, z, sign, mag};
   endfunction

   always_ff @(posedge i_clk) begin
      if (load) begin
         wrk <= {i_dividend[M-1:0], {Q{1'b0}}};
         rem <= '0;
         dvs <= i_divisor[M-1:0];
         sgn <= i_dividend[N-1] ^ i_divisor[N-1];
         dz  <= ~|i_divisor[M-1:0];
      end else if (state == RUN && cnt != '0) begin
         wrk <= {wrk[W-2:0], ge};
         rem <= rem_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_quotient <= '0;
         o_ovr      <= 1'b0;
         o_div_zero <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state  <= RUN;
                  cnt    <= CW'(W);
                  o_busy <= 1'b1;
               end else begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            RUN: begin
               // W restoring steps, then one cycle to saturate and sign the result
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state  <= DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  {o_ovr, o_div_zero, o_quotient} <= form_result(wrk, sgn, dz);
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq: hand-computed quotients, fixed latency, and handshake/reset behaviour.
module tb_qdiv_seq;

   localparam int Q = 16;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic         ovr;
   logic         div_zero;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   qdiv_seq #(.Q(Q), .N(N)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .o_busy     (busy),
      .o_done     (done),
      .o_quotient (quotient),
      .o_ovr      (ovr),
      .o_div_zero (div_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Drives a start for one edge, then scrambles the operand inputs
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Counts edges until o_done; optionally pokes a stray start at edge poke_at
   task automatic wait_done(input string tag, input logic [N-1:0] eq, input logic eovr,
                            input logic edz, input int poke_at);
      int   edges = 0;
      logic busy_ok = 1'b1;
      chk({tag, " busy@start"}, 64'(busy), 64'd1);
      while (edges < 100) begin
         if (edges == poke_at) begin
            dividend = 32'h0001_0000;
            divisor  = 32'h0003_0000;
            start    = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         edges++;
         if (done) break;
         if (!busy) busy_ok = 1'b0;
      end
      chk({tag, " latency"}, 64'(edges), 64'd48);
      chk({tag, " busy-run"}, 64'(busy_ok), 64'd1);
      chk({tag, " busy@done"}, 64'(busy), 64'd0);
      chk({tag, " quotient"}, 64'(quotient), 64'(eq));
      chk({tag, " ovr"}, 64'(ovr), 64'(eovr));
      chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst quotient", 64'(quotient), 64'd0);
      chk("rst flags", 64'({ovr, div_zero}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 6.0 / 2.0 with a stray start at cycle 10, then back-to-back 1.0 / 3.0 issued during DONE
      issue(32'h0006_0000, 32'h0002_0000);
      wait_done("6/2", 32'h0003_0000, 1'b0, 1'b0, 10);
      issue(32'h0001_0000, 32'h0003_0000);
      wait_done("1/3", 32'h0000_5555, 1'b0, 1'b0, -1);
      @(posedge clk);
      #1;
      chk("hold done", 64'(done), 64'd0);
      chk("hold busy", 64'(busy), 64'd0);
      chk("hold quotient", 64'(quotient), 64'h0000_5555);

      issue(32'h8001_8000, 32'h0000_8000);
      wait_done("-1.5/0.5", 32'h8003_0000, 1'b0, 1'b0, -1);
      issue(32'h4000_0000, 32'h0000_0001);
      wait_done("sat", 32'h7FFF_FFFF, 1'b1, 1'b0, -1);
      issue(32'h8001_0000, 32'h0000_0000);
      wait_done("divzero", 32'hFFFF_FFFF, 1'b0, 1'b1, -1);
      issue(32'h8000_0000, 32'h0001_0000);
      wait_done("negzero", 32'h0000_0000, 1'b0, 1'b0, -1);
      @(posedge clk);
      #1;

      // Reset in cycle 20 of a divide abandons it silently
      begin
         logic saw_done = 1'b0;
         issue(32'h8001_8000, 32'h0000_8000);
         repeat (19) @(posedge clk);
         #1;
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         chk("midrst busy", 64'(busy), 64'd0);
         chk("midrst done", 64'(done), 64'd0);
         chk("midrst quotient", 64'(quotient), 64'd0);
         chk("midrst flags", 64'({ovr, div_zero}), 64'd0);
         rst_n = 1'b1;
         for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
         end
         chk("midrst no-done", 64'(saw_done), 64'd0);
      end

      issue(32'h0006_0000, 32'h0002_0000);
      wait_done("post-rst 6/2", 32'h0003_0000, 1'b0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
